king_locator: RTL and testbench

Sequential scanner that walks the 64-entry board one square per clock and reports where each side's king stands. It produces the king square consumed by the king-on-position check and the attack-detection stages (e.g. rook-attack test on the king square). It also flags boards that do not hold exactly one king per colour, so downstream move validation can reject corrupt positions.

---
 rtl/king_locator.sv | 153 +++++++++++++++
 tb/tb_king_locator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/king_locator.sv
// rtl/king_locator.sv - sequential king finder with per-colour count and board legality flag
//
// chesstypes: shared piece/colour encodings for the board array.
//
// king_locator ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   board[63:0]                      board squares (.piece, .color); index[5:3]=row, [2:0]=col
//   playing                          side to move, latched when a scan is accepted
//   start                            scan request, honoured only while idle
//   busy                             high from the accepted start until the done cycle ends
//   done                             one-cycle pulse, results valid from here on
//   own_king_pos/found/count         lowest own-king square, seen flag, saturating count
//   opp_king_pos/found/count         same for the opponent colour
//   board_legal                      exactly one king per colour, updated as done rises

package chesstypes;
    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } color_t;

    typedef struct packed {
        piece_t piece;
        color_t color;
    } fullpiece_t;
endpackage

module king_locator
    import chesstypes::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  fullpiece_t [63:0] board,
    input  color_t            playing,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [5:0]        own_king_pos,
    output logic              own_king_found,
    output logic [1:0]        own_king_count,
    output logic [5:0]        opp_king_pos,
    output logic              opp_king_found,
    output logic [1:0]        opp_king_count,
    output logic              board_legal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] idx;
    color_t     side;
    fullpiece_t cur;
    logic       own_hit;
    logic       opp_hit;
    logic [1:0] own_cnt_nxt;
    logic [1:0] opp_cnt_nxt;

    // Square under examination and how it affects each path this cycle.
    always_comb begin
        cur         = board[idx];
        own_hit     = (cur.piece == KING) && (cur.color == side);
        opp_hit     = (cur.piece == KING) && (cur.color != side);
        own_cnt_nxt = own_king_count;
        opp_cnt_nxt = opp_king_count;
        if (own_hit && own_king_count != 2'd3) begin
            own_cnt_nxt = own_king_count + 2'd1;
        end
        if (opp_hit && opp_king_count != 2'd3) begin
            opp_cnt_nxt = opp_king_count + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (idx == 6'd63) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            idx            <= 6'd0;
            side           <= WHITE;
            own_king_pos   <= 6'd0;
            own_king_found <= 1'b0;
            own_king_count <= 2'd0;
            opp_king_pos   <= 6'd0;
            opp_king_found <= 1'b0;
            opp_king_count <= 2'd0;
            board_legal    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Flags follow the next state so they are plain register outputs.
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);

            if (state == IDLE && start) begin
                side           <= playing;
                idx            <= 6'd0;
                own_king_pos   <= 6'd0;
                own_king_found <= 1'b0;
                own_king_count <= 2'd0;
                opp_king_pos   <= 6'd0;
                opp_king_found <= 1'b0;
                opp_king_count <= 2'd0;
                board_legal    <= 1'b0;
            end else if (state == SCAN) begin
                if (own_hit) begin
                    if (!own_king_found) begin
                        own_king_pos   <= idx;
                        own_king_found <= 1'b1;
                    end
                    own_king_count <= own_cnt_nxt;
                end
                if (opp_hit) begin
                    if (!opp_king_found) begin
                        opp_king_pos   <= idx;
                        opp_king_found <= 1'b1;
                    end
                    opp_king_count <= opp_cnt_nxt;
                end
                // Last square: freeze idx and judge legality from the final counts.
                if (idx == 6'd63) begin
                    board_legal <= (own_cnt_nxt == 2'd1) && (opp_cnt_nxt == 2'd1);
                end else begin
                    idx <= idx + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_king_locator.sv
// tb/tb_king_locator.sv - scoreboard bench for king_locator

module tb_king_locator;
    import chesstypes::*;

    typedef struct packed {
        logic [5:0] own_pos;
        logic       own_found;
        logic [1:0] own_cnt;
        logic [5:0] opp_pos;
        logic       opp_found;
        logic [1:0] opp_cnt;
        logic       legal;
    } res_t;

    logic              clk;
    logic              rst_n;
    fullpiece_t [63:0] board;
    color_t            playing;
    logic              start;
    logic              busy;
    logic              done;
    logic [5:0]        own_king_pos;
    logic              own_king_found;
    logic [1:0]        own_king_count;
    logic [5:0]        opp_king_pos;
    logic              opp_king_found;
    logic [1:0]        opp_king_count;
    logic              board_legal;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    fullpiece_t [63:0] tb_b;

    king_locator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .board          (board),
        .playing        (playing),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .own_king_pos   (own_king_pos),
        .own_king_found (own_king_found),
        .own_king_count (own_king_count),
        .opp_king_pos   (opp_king_pos),
        .opp_king_found (opp_king_found),
        .opp_king_count (opp_king_count),
        .board_legal    (board_legal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input fullpiece_t [63:0] b, input color_t p);
        res_t r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i].piece == KING) begin
                if (b[i].color == p) begin
                    if (!r.own_found) r.own_pos = 6'(i);
                    r.own_found = 1'b1;
                    if (r.own_cnt != 2'd3) r.own_cnt = r.own_cnt + 2'd1;
                end else begin
                    if (!r.opp_found) r.opp_pos = 6'(i);
                    r.opp_found = 1'b1;
                    if (r.opp_cnt != 2'd3) r.opp_cnt = r.opp_cnt + 2'd1;
                end
            end
        end
        r.legal = (r.own_cnt == 2'd1) && (r.opp_cnt == 2'd1);
        return r;
    endfunction

    task automatic place(input int sq, input piece_t pc, input color_t c);
        tb_b[sq].piece = pc;
        tb_b[sq].color = c;
    endtask

    function automatic logic [31:0] outs_packed();
        return {18'd0, busy, done, own_king_pos, own_king_found, own_king_count,
                opp_king_pos, opp_king_found, opp_king_count, board_legal};
    endfunction

    // One scan: push the model's answer on start, pop and compare on done.
    // poke adds stray starts in cycles 5 and 64 and flips playing in cycle 20.
    task automatic run_scan(input string name, input color_t p, input bit poke);
        int   cyc;
        int   dones;
        int   busy_low;
        bit   got;
        res_t e;
        board   = tb_b;
        playing = p;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(model(tb_b, p));
        dones = 0; busy_low = 0; got = 0; cyc = 1;
        @(negedge clk);
        while (!got && cyc <= 200) begin
            start = poke && (cyc == 5 || cyc == 64);
            if (poke && cyc == 20) playing = color_t'(~p);
            if (done) begin
                got = 1'b1;
                dones++;
                expect_eq({name, " latency"}, cyc, 65);
                expect_eq({name, " busy_at_done"}, busy, 1);
                e = exp_q.pop_front();
                expect_eq({name, " own_pos"}, own_king_pos, e.own_pos);
                expect_eq({name, " own_found"}, own_king_found, e.own_found);
                expect_eq({name, " own_cnt"}, own_king_count, e.own_cnt);
                expect_eq({name, " opp_pos"}, opp_king_pos, e.opp_pos);
                expect_eq({name, " opp_found"}, opp_king_found, e.opp_found);
                expect_eq({name, " opp_cnt"}, opp_king_count, e.opp_cnt);
                expect_eq({name, " legal"}, board_legal, e.legal);
            end else begin
                if (!busy) busy_low++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got) begin
            expect_eq({name, " done_timeout"}, 0, 1);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        expect_eq({name, " busy_after"}, busy, 0);
        expect_eq({name, " done_after"}, done, 0);
        expect_eq({name, " legal_held"}, board_legal, e.legal);
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        expect_eq({name, " done_pulses"}, dones, 1);
        expect_eq({name, " busy_gaps"}, busy_low, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        playing = WHITE;
        tb_b    = '0;
        board   = '0;
        repeat (3) @(negedge clk);
        expect_eq("reset_outputs", outs_packed(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // e1 / e8 kings, both sides to move, then a playing flip mid-scan.
        tb_b = '0;
        place(4, KING, WHITE);
        place(60, KING, BLACK);
        place(0, ROOK, WHITE);
        place(59, QUEEN, BLACK);
        run_scan("e1e8_white", WHITE, 1'b0);
        run_scan("e1e8_black", BLACK, 1'b0);
        run_scan("e1e8_poke", BLACK, 1'b1);

        // Too many own kings: saturation and illegal board.
        tb_b = '0;
        place(3, KING, WHITE);
        place(10, KING, WHITE);
        place(63, KING, WHITE);
        place(20, KING, WHITE);
        place(0, KING, BLACK);
        place(1, QUEEN, BLACK);
        place(2, ROOK, WHITE);
        run_scan("sat_white", WHITE, 1'b0);

        // Empty board.
        tb_b = '0;
        run_scan("empty", WHITE, 1'b0);

        // Kings on the final square and one before it.
        tb_b = '0;
        place(62, KING, WHITE);
        place(63, KING, BLACK);
        run_scan("last_sq", BLACK, 1'b0);

        // Reset in the middle of a scan aborts it.
        tb_b = '0;
        place(4, KING, WHITE);
        place(60, KING, BLACK);
        board   = tb_b;
        playing = WHITE;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_eq("abort_outputs", outs_packed(), 0);
        begin
            int stray;
            stray = 0;
            repeat (3) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            rst_n = 1'b1;
            repeat (70) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            expect_eq("abort_no_done", stray, 0);
        end
        run_scan("after_reset", WHITE, 1'b0);

        // Random boards with sparse kings.
        for (int t = 0; t < 3; t++) begin
            tb_b = '0;
            for (int s = 0; s < 64; s++) begin
                if ($urandom_range(0, 15) == 0) begin
                    place(s, piece_t'($urandom_range(1, 6)), color_t'($urandom_range(0, 1)));
                end
            end
            run_scan($sformatf("rand%0d", t), color_t'(t & 1), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
